// File: rtl/ped_countdown_digits.sv
// Two-digit BCD pedestrian countdown timer driving tens/ones 7-segment decoder codes.
// Idle display is blank/"P"; counts down once per TICK_DIV cycles after a start request.
module ped_countdown_digits #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned MAX_SECS = 99
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [6:0] load_secs,
  input  logic       hold,
  output logic [3:0] tens_value,
  output logic [3:0] ones_value,
  output logic       busy,
  output logic       done
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [3:0] CODE_P     = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic [3:0]    tens_value_q, tens_value_d;
  logic [3:0]    ones_value_q, ones_value_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [6:0]    secs_c;
  logic [3:0]    ld_tens_c;
  logic [3:0]    ld_ones_c;
  logic          tick_c;
  logic          last_c;

  // Clamp the requested value and split it into BCD digits.
  always_comb begin
    secs_c    = (load_secs > 7'(MAX_SECS)) ? 7'(MAX_SECS) : load_secs;
    ld_tens_c = 4'(secs_c / 7'd10);
    ld_ones_c = 4'(secs_c % 7'd10);
    tick_c    = (presc_q == PW'(TICK_DIV - 1));
    last_c    = (tens_q == 4'd0) && (ones_q == 4'd1);
  end

  // Next-state, counter and display logic; priority start > hold > tick.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (load_secs == 7'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            presc_d = '0;
            tens_d  = ld_tens_c;
            ones_d  = ld_ones_c;
          end
        end
      end
      RUN: begin
        if (start) begin
          presc_d = '0;
          if (load_secs == 7'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            tens_d = ld_tens_c;
            ones_d = ld_ones_c;
          end
        end else if (!hold) begin
          if (tick_c) begin
            presc_d = '0;
            if (last_c) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else if (ones_q == 4'd0) begin
              ones_d = 4'd9;
              tens_d = tens_q - 4'd1;
            end else begin
              ones_d = ones_q - 4'd1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    if (state_d == RUN) begin
      tens_value_d = (tens_d == 4'd0) ? CODE_BLANK : tens_d;
      ones_value_d = ones_d;
    end else begin
      tens_value_d = CODE_BLANK;
      ones_value_d = CODE_P;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      tens_q       <= 4'd0;
      ones_q       <= 4'd0;
      tens_value_q <= CODE_BLANK;
      ones_value_q <= CODE_P;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      tens_q       <= tens_d;
      ones_q       <= ones_d;
      tens_value_q <= tens_value_d;
      ones_value_q <= ones_value_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign tens_value = tens_value_q;
  assign ones_value = ones_value_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_ped_countdown_digits.sv
// Directed bench for ped_countdown_digits with TICK_DIV=4, MAX_SECS=99.
module tb_ped_countdown_digits;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [6:0] load_secs;
  logic       hold;
  logic [3:0] tens_value;
  logic [3:0] ones_value;
  logic       busy;
  logic       done;

  int n_tests;
  int n_fail;

  ped_countdown_digits #(.TICK_DIV(4), .MAX_SECS(99)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .load_secs  (load_secs),
    .hold       (hold),
    .tens_value (tens_value),
    .ones_value (ones_value),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Expected {tens,ones,busy,done} while counting value v (1..99).
  function automatic logic [9:0] run_word(input int v);
    logic [3:0] t;
    t = 4'(v / 10);
    if (t == 4'd0) t = 4'hF;
    return {t, 4'(v % 10), 1'b1, 1'b0};
  endfunction

  localparam logic [9:0] IDLE_WORD = {4'hF, 4'hA, 1'b0, 1'b0};
  localparam logic [9:0] DONE_WORD = {4'hF, 4'hA, 1'b0, 1'b1};

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; start = 1'b0; hold = 1'b0; load_secs = 7'd0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 21; i++) begin
      n_tests++;
      if ({tens_value, ones_value, busy, done} !== IDLE_WORD) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: got %h want %h", i,
                 {tens_value, ones_value, busy, done}, IDLE_WORD);
      end
      step();
    end
  endtask

  task automatic test_borrow();
    int vals [3];
    logic [9:0] exp;
    vals = '{10, 9, 8};
    do_reset();
    start = 1'b1; load_secs = 7'd10;
    step();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      exp = run_word(vals[i / 4]);
      n_tests++;
      if ({tens_value, ones_value, busy, done} !== exp) begin
        n_fail++;
        $display("FAIL borrow cyc %0d: got %h want %h", i,
                 {tens_value, ones_value, busy, done}, exp);
      end
      step();
    end
  endtask

  task automatic test_expiry();
    logic [9:0] exp;
    do_reset();
    start = 1'b1; load_secs = 7'd3;
    step();
    start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (i < 12) exp = run_word(3 - i / 4);
      else if (i == 12) exp = DONE_WORD;
      else exp = IDLE_WORD;
      n_tests++;
      if ({tens_value, ones_value, busy, done} !== exp) begin
        n_fail++;
        $display("FAIL expiry cyc %0d: got %h want %h", i,
                 {tens_value, ones_value, busy, done}, exp);
      end
      step();
    end
  endtask

  task automatic test_hold();
    logic [9:0] exp;
    do_reset();
    start = 1'b1; load_secs = 7'd5;
    step();
    start = 1'b0;
    for (int c = 0; c < 28; c++) begin
      hold = (c >= 1 && c <= 6);
      if (c < 10) exp = run_word(5);
      else if (c < 26) exp = run_word(5 - (c - 6) / 4);
      else if (c == 26) exp = DONE_WORD;
      else exp = IDLE_WORD;
      n_tests++;
      if ({tens_value, ones_value, busy, done} !== exp) begin
        n_fail++;
        $display("FAIL hold cyc %0d: got %h want %h", c,
                 {tens_value, ones_value, busy, done}, exp);
      end
      step();
    end
    hold = 1'b0;
  endtask

  task automatic test_zero_and_clamp();
    do_reset();
    hold = 1'b1;
    start = 1'b1; load_secs = 7'd0;
    step();
    start = 1'b0; hold = 1'b0;
    n_tests++;
    if ({tens_value, ones_value, busy, done} !== DONE_WORD) begin
      n_fail++;
      $display("FAIL zero_load: got %h want %h", {tens_value, ones_value, busy, done}, DONE_WORD);
    end
    step();
    n_tests++;
    if ({tens_value, ones_value, busy, done} !== IDLE_WORD) begin
      n_fail++;
      $display("FAIL zero_after: got %h want %h", {tens_value, ones_value, busy, done}, IDLE_WORD);
    end
    start = 1'b1; load_secs = 7'd120;
    step();
    start = 1'b0;
    n_tests++;
    if ({tens_value, ones_value, busy, done} !== {4'h9, 4'h9, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL clamp: got %h want %h", {tens_value, ones_value, busy, done},
               {4'h9, 4'h9, 1'b1, 1'b0});
    end
  endtask

  task automatic test_reload_and_reset();
    logic [9:0] exp;
    do_reset();
    start = 1'b1; load_secs = 7'd42;
    step();
    start = 1'b0;
    n_tests++;
    if ({tens_value, ones_value, busy, done} !== run_word(42)) begin
      n_fail++;
      $display("FAIL show_42: got %h want %h", {tens_value, ones_value, busy, done}, run_word(42));
    end
    step();
    start = 1'b1; load_secs = 7'd7;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp = (i < 4) ? run_word(7) : run_word(6);
      n_tests++;
      if ({tens_value, ones_value, busy, done} !== exp) begin
        n_fail++;
        $display("FAIL reload cyc %0d: got %h want %h", i,
                 {tens_value, ones_value, busy, done}, exp);
      end
      if (i < 4) step();
    end
    reset_n = 1'b0;
    step();
    n_tests++;
    if ({tens_value, ones_value, busy, done} !== IDLE_WORD) begin
      n_fail++;
      $display("FAIL midcount_reset: got %h want %h", {tens_value, ones_value, busy, done}, IDLE_WORD);
    end
    reset_n = 1'b1;
    step();
    n_tests++;
    if ({tens_value, ones_value, busy, done} !== IDLE_WORD) begin
      n_fail++;
      $display("FAIL post_reset: got %h want %h", {tens_value, ones_value, busy, done}, IDLE_WORD);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0; start = 1'b0; hold = 1'b0; load_secs = 7'd0;
    @(negedge clk);
    test_reset();
    test_borrow();
    test_expiry();
    test_hold();
    test_zero_and_clamp();
    test_reload_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ped_countdown_digits.md
Name: ped_countdown_digits

Overview:
- Two-digit pedestrian countdown timer for the traffic-light controller.
- On a start request it loads a seconds value and counts down once per second in BCD.
- Outputs two 4-bit digit codes that drive the tens and ones 7-segment decoders directly.
- When idle the display shows blank on the tens digit and "P" on the ones digit.

Parameters:
- TICK_DIV, 50000000, clock cycles per one-second tick (must be >= 2).
- MAX_SECS, 99, saturation limit for load_secs (must be <= 99).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset.
- start  in  1  load request, sampled every rising edge.
- load_secs  in  7  initial seconds, unsigned binary.
- hold  in  1  freeze the countdown while high.
- tens_value  out  4  tens digit code for the decoder.
- ones_value  out  4  ones digit code for the decoder.
- busy  out  1  high while counting.
- done  out  1  one-cycle pulse at expiry.

Behaviour:
- Interface:
  - One clock, clk.
  - reset_n is synchronous and active-low.
  - All outputs are registered.
- Digit codes:
  - 0-9 are BCD digits.
  - 4'hA = "P".
  - 4'hF = blank.
- Reset (reset_n low at a rising edge):
  - state=IDLE, prescaler=0.
  - tens_value=4'hF, ones_value=4'hA.
  - busy=0, done=0.
- States: IDLE, RUN.
- IDLE:
  - Outputs F/A, busy=0.
  - start=1 with load_secs=0: done=1 on the next cycle; stay IDLE.
  - start=1 with load_secs>0:
    - Value is clamped to MAX_SECS.
    - Converted to BCD (tens = v/10, ones = v%10).
    - Next cycle: state=RUN, busy=1, prescaler=0, digits show the loaded value.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps; the wrap cycle is the tick.
  - Each loaded/decremented value is displayed for exactly TICK_DIV cycles.
  - On a tick with value > 1: decrement in BCD.
    - ones 0 -> 9 with tens-1; otherwise ones-1.
  - On a tick with value == 1 (return to IDLE):
    - Next cycle: state=IDLE, digits F/A, busy=0.
    - done=1 for exactly that one cycle.
  - Leading-zero blanking: when the tens digit is 0, tens_value outputs 4'hF. The internal BCD still holds 0.
- hold=1 in RUN:
  - Prescaler and digits freeze; no tick occurs.
  - Counting resumes from the frozen prescaler value when hold drops.
  - hold has no effect in IDLE.
- Priority when events coincide in one cycle: reset > start > hold > tick.
  - start in RUN reloads immediately (clamp, prescaler cleared, busy stays 1, no done pulse).
  - start with load_secs=0 in RUN: abort to IDLE, done=1 next cycle.
- done never asserts for two consecutive cycles unless start with load_secs=0 is held high continuously. In that case it pulses each cycle, which is acceptable.
- Reset mid-count: immediate return to reset values at that edge; no done pulse.
- Undefined internal codes are never output; tens_value/ones_value are always in {0-9, A, F}.

Test Plan (TICK_DIV=4, MAX_SECS=99 in simulation):
1. Hold reset_n low 2 cycles, release -> tens_value=F, ones_value=A, busy=0, done=0 and stable for 20 cycles with start=0.
2. start=1 for one cycle, load_secs=10 -> next cycle tens/ones=1/0, busy=1; 4 cycles later F/9 (borrow and blanking); 4 cycles later F/8.
3. start, load_secs=3 -> F/3 for 4 cycles, F/2 for 4, F/1 for 4; then done=1 for exactly one cycle with F/A and busy=0; total 13 cycles from the start edge to the done cycle.
4. load_secs=5, assert hold for 6 cycles after 2 cycles of F/5 -> F/5 is displayed for 10 cycles in total; expiry occurs 6 cycles later than in the unheld run.
5. start with load_secs=0 in IDLE -> done=1 one cycle later, busy stays 0. start with load_secs=120 -> 9/9 displayed (clamped).
6. Mid-count (showing 4/2): assert start with load_secs=7 -> next cycle F/7, prescaler restarted. Then drive reset_n low at one edge while showing F/6 -> F/A, busy=0, done=0 at that edge.
